// File: rtl/hazard_control_unit.sv
// Hazard control unit for the five-stage LC-3b pipeline.
//
// Decides, every cycle, which pipeline registers advance, whether ID/EX takes
// a bubble, and whether the front of the pipe is flushed after a redirect.
// All control outputs are combinational from the inputs and current state.
// The only other outputs are the registered imem_hold flag and a saturating
// count of cycles in which the PC did not load.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   id_sr1/id_sr2, id_uses_sr1/2    ID-stage source registers and their use
//   exec_mem_read, exec_reg_write   EX instruction is a load / writes a reg
//   exec_dest                       EX destination register
//   imem_read, imem_resp            fetch request / I-cache response
//   dmem_read/write, dmem_resp      MEM-stage request / D-cache response
//   mem_br_taken                    redirect resolved in MEM
//   load_pc .. load_mem_wb          pipeline-register load enables
//   bubble_id_ex                    ID/EX loads a NOP
//   flush                           IF/ID, ID/EX, EX/MEM load NOPs
//   imem_hold                       fetched word is being held; do not reissue
//   stall_cycles                    saturating count of cycles with load_pc=0
module hazard_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  id_sr1,
  input  logic [2:0]  id_sr2,
  input  logic        id_uses_sr1,
  input  logic        id_uses_sr2,
  input  logic        exec_mem_read,
  input  logic        exec_reg_write,
  input  logic [2:0]  exec_dest,
  input  logic        imem_read,
  input  logic        imem_resp,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic        dmem_resp,
  input  logic        mem_br_taken,
  output logic        load_pc,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        bubble_id_ex,
  output logic        flush,
  output logic        imem_hold,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StFlushRecover
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        r_imem_done;
  logic        w_imem_done_next;
  logic [15:0] r_stall_cnt;

  logic w_dbusy;
  logic w_ibusy;
  logic w_load_use;
  logic w_sr1_hit;
  logic w_sr2_hit;
  logic w_recovering;

  // A fetch that already returned while the pipe was frozen is not busy again.
  assign w_dbusy      = (dmem_read | dmem_write) & ~dmem_resp;
  assign w_ibusy      = imem_read & ~imem_resp & ~r_imem_done;
  assign w_sr1_hit    = id_uses_sr1 & (id_sr1 == exec_dest);
  assign w_sr2_hit    = id_uses_sr2 & (id_sr2 == exec_dest);
  assign w_load_use   = exec_mem_read & exec_reg_write & (w_sr1_hit | w_sr2_hit);
  assign w_recovering = (r_state == StFlushRecover);

  always_comb begin
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    load_id_ex   = 1'b1;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    bubble_id_ex = 1'b0;
    flush        = 1'b0;
    w_state_next = StRun;

    if (reset) begin
      w_state_next = StRun;
    end else if (w_dbusy || w_ibusy) begin
      // Memory stall freezes the whole pipe, including any pending redirect.
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
      w_state_next = StMemWait;
    end else if (!w_recovering && mem_br_taken) begin
      flush        = 1'b1;
      w_state_next = StFlushRecover;
    end else if (!w_recovering && w_load_use) begin
      // Hold IF and ID one cycle; the load advances and a NOP enters EX.
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      bubble_id_ex = 1'b1;
      w_state_next = StRun;
    end else begin
      // In the recovery cycle ID holds a squashed NOP, so hazards are ignored.
      w_state_next = StRun;
    end
  end

  always_comb begin
    w_imem_done_next = r_imem_done;
    if (load_if_id || flush) begin
      w_imem_done_next = 1'b0;
    end else if (imem_resp) begin
      w_imem_done_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StRun;
      r_imem_done <= 1'b0;
      r_stall_cnt <= 16'h0000;
    end else begin
      r_state     <= w_state_next;
      r_imem_done <= w_imem_done_next;
      if (!load_pc && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'h0001;
      end
    end
  end

  // Gated by reset so the flag reads 0 before the first reset edge lands.
  assign imem_hold    = r_imem_done & ~reset;
  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  id_sr1, id_sr2, exec_dest;
  logic        id_uses_sr1, id_uses_sr2, exec_mem_read, exec_reg_write;
  logic        imem_read, imem_resp, dmem_read, dmem_write, dmem_resp, mem_br_taken;
  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        bubble_id_ex, flush, imem_hold;
  logic [15:0] stall_cycles;

  hazard_control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .id_sr1        (id_sr1),
    .id_sr2        (id_sr2),
    .id_uses_sr1   (id_uses_sr1),
    .id_uses_sr2   (id_uses_sr2),
    .exec_mem_read (exec_mem_read),
    .exec_reg_write(exec_reg_write),
    .exec_dest     (exec_dest),
    .imem_read     (imem_read),
    .imem_resp     (imem_resp),
    .dmem_read     (dmem_read),
    .dmem_write    (dmem_write),
    .dmem_resp     (dmem_resp),
    .mem_br_taken  (mem_br_taken),
    .load_pc       (load_pc),
    .load_if_id    (load_if_id),
    .load_id_ex    (load_id_ex),
    .load_ex_mem   (load_ex_mem),
    .load_mem_wb   (load_mem_wb),
    .bubble_id_ex  (bubble_id_ex),
    .flush         (flush),
    .imem_hold     (imem_hold),
    .stall_cycles  (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit       rst;
    bit [2:0] sr1;
    bit [2:0] sr2;
    bit       u1;
    bit       u2;
    bit       emr;
    bit       erw;
    bit [2:0] ed;
    bit       ir;
    bit       iresp;
    bit       dr;
    bit       dw;
    bit       dresp;
    bit       br;
  } stim_t;

  // ctl = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, bubble, flush, hold}
  typedef struct packed {
    logic [7:0]  ctl;
    logic [15:0] stall;
    int          tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model: behaviour described in terms of "what happened last cycle".
  int m_stalls;
  bit m_held;       // a fetched word is being held while the pipe is frozen
  bit m_after_flush; // previous cycle flushed, ID now holds a squashed NOP

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.ir    = 1'b1;
    s.iresp = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    bit dbusy, ibusy, lu, freeze, do_flush, do_bubble;
    bit lpc, lif;
    reset = s.rst;  id_sr1 = s.sr1;  id_sr2 = s.sr2;  id_uses_sr1 = s.u1;
    id_uses_sr2 = s.u2;  exec_mem_read = s.emr;  exec_reg_write = s.erw;
    exec_dest = s.ed;  imem_read = s.ir;  imem_resp = s.iresp;  dmem_read = s.dr;
    dmem_write = s.dw;  dmem_resp = s.dresp;  mem_br_taken = s.br;

    e.stall = (m_stalls > 65535) ? 16'hFFFF : 16'(m_stalls);
    e.tag   = cyc;
    if (s.rst) begin
      e.ctl = 8'b1111_1000;
      m_stalls = 0;
      m_held = 0;
      m_after_flush = 0;
    end else begin
      dbusy = (s.dr || s.dw) && !s.dresp;
      ibusy = s.ir && !s.iresp && !m_held;
      lu = s.emr && s.erw && ((s.u1 && s.sr1 == s.ed) || (s.u2 && s.sr2 == s.ed));
      freeze    = dbusy || ibusy;
      do_flush  = !freeze && !m_after_flush && s.br;
      do_bubble = !freeze && !m_after_flush && !s.br && lu;
      lpc = !freeze && !do_bubble;
      lif = lpc;
      e.ctl = {lpc, lif, !freeze, !freeze, !freeze, do_bubble, do_flush, m_held};
      if (!lpc) m_stalls++;
      if (lif) m_held = 0;
      else if (s.iresp) m_held = 1;
      m_after_flush = do_flush;
    end
    sb_q.push_back(e);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] act;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
             bubble_id_ex, flush, imem_hold};
      checks++;
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL ctl cyc=%0d got=%b want=%b", e.tag, act, e.ctl);
      end
      checks++;
      if (stall_cycles !== e.stall) begin
        failures++;
        $display("FAIL stall_cycles cyc=%0d got=%h want=%h", e.tag, stall_cycles, e.stall);
      end
    end
  end

  initial begin
    stim_t s;
    m_stalls = 0;
    m_held = 0;
    m_after_flush = 0;
    {id_sr1, id_sr2, exec_dest} = '0;
    {id_uses_sr1, id_uses_sr2, exec_mem_read, exec_reg_write} = '0;
    {imem_read, imem_resp, dmem_read, dmem_write, dmem_resp, mem_br_taken} = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset state.
    s = idle(); s.rst = 1; drive(s);
    s = idle(); drive(s);

    // Load-use: LDR R2 in EX, ADD R3,R2,R1 in ID.
    s = idle(); s.emr = 1; s.erw = 1; s.ed = 3'd2;
    s.sr1 = 3'd2; s.sr2 = 3'd1; s.u1 = 1; s.u2 = 1; drive(s);
    s.emr = 0; drive(s);

    // D-miss four cycles, with a fetch response landing in cycle 2.
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.dr = 1; s.dresp = (i == 4);
      s.iresp = (i == 1); drive(s);
    end
    s = idle(); drive(s);

    // Branch and load-use together, then load-use during recovery.
    s = idle(); s.emr = 1; s.erw = 1; s.ed = 3'd5; s.sr2 = 3'd5; s.u2 = 1;
    s.br = 1; drive(s);
    s.br = 0; drive(s);
    drive(s);

    // Reset in the middle of a D-miss.
    s = idle(); s.dw = 1; drive(s); drive(s);
    s.rst = 1; drive(s);
    s = idle(); drive(s); drive(s);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s.rst   = ($urandom_range(0, 99) < 2);
      s.sr1   = 3'($urandom_range(0, 3));
      s.sr2   = 3'($urandom_range(0, 3));
      s.ed    = 3'($urandom_range(0, 3));
      s.u1    = 1'($urandom);
      s.u2    = 1'($urandom);
      s.emr   = ($urandom_range(0, 99) < 40);
      s.erw   = ($urandom_range(0, 99) < 80);
      s.ir    = ($urandom_range(0, 99) < 85);
      s.iresp = ($urandom_range(0, 99) < 60);
      s.dr    = ($urandom_range(0, 99) < 25);
      s.dw    = ($urandom_range(0, 99) < 10);
      s.dresp = ($urandom_range(0, 99) < 50);
      s.br    = ($urandom_range(0, 99) < 15);
      drive(s);
    end

    // Saturation: long D-miss, then reset clears the counter.
    s = idle(); s.rst = 1; drive(s);
    s = idle(); s.dr = 1;
    for (int i = 0; i < 70000; i++) drive(s);
    s = idle(); drive(s);
    s.rst = 1; drive(s);
    s.rst = 0; drive(s);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: id_sr1, id_sr2  input  lc3b_reg (3)  source registers of the instruction in ID.
REQ-004 SHALL have port: id_uses_sr1, id_uses_sr2  input  1 each  ID instruction reads that source (id_uses_sr2=0 for immediate forms).
REQ-005 SHALL have port: exec_mem_read, exec_reg_write  input  1 each  EX instruction is a load / writes a register.
REQ-006 SHALL have port: exec_dest  input  lc3b_reg (3)  EX destination register.
REQ-007 SHALL have port: imem_read, imem_resp  input  1 each  fetch request / I-cache response.
REQ-008 SHALL have port: dmem_read, dmem_write, dmem_resp  input  1 each  MEM-stage request / D-cache response.
REQ-009 SHALL have port: mem_br_taken  input  1  redirect (taken BR/JMP/JSR/TRAP) resolved in MEM.
REQ-010 SHALL have port: load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  pipeline-register load enables.
REQ-011 SHALL have port: bubble_id_ex  output  1  ID/EX loads a NOP this cycle.
REQ-012 SHALL have port: flush  output  1  IF/ID, ID/EX, EX/MEM load NOPs this cycle.
REQ-013 SHALL have port: imem_hold  output  1  fetch already returned; fetch stage uses its held word and does not reissue.
REQ-014 SHALL have port: stall_cycles  output  16  saturating count of cycles with load_pc=0.

Function
REQ-015 SHALL define dbusy = (dmem_read|dmem_write) & ~dmem_resp; ibusy = imem_read & ~imem_resp & ~imem_done.
REQ-016 SHALL define load_use = exec_mem_read & exec_reg_write & ((id_uses_sr1 & id_sr1==exec_dest) | (id_uses_sr2 & id_sr2==exec_dest)).
REQ-017 SHALL implement a 3-state FSM: RUN, MEM_WAIT, FLUSH_RECOVER.
REQ-018 SHALL, in any state with dbusy=1 or ibusy=1: drive all five load enables 0, bubble_id_ex=0, flush=0; next state MEM_WAIT.
REQ-019 SHALL, in MEM_WAIT with dbusy=0 and ibusy=0: drive all loads 1 that cycle (evaluate REQ-020/021 identically to RUN); next state RUN, or FLUSH_RECOVER if flush asserted.
REQ-020 SHALL, in RUN/MEM_WAIT with no busy and mem_br_taken=1: drive all loads 1, flush=1, bubble_id_ex=0; next state FLUSH_RECOVER; mem_br_taken has priority over load_use.
REQ-021 SHALL, with no busy, no mem_br_taken and load_use=1: drive load_pc=0, load_if_id=0, bubble_id_ex=1, load_id_ex/ex_mem/mem_wb=1; state unchanged (one bubble per load-use).
REQ-022 SHALL, in FLUSH_RECOVER for exactly one cycle: ignore load_use (ID holds a squashed NOP), drive all loads 1 unless busy (REQ-018 wins); next state RUN.
REQ-023 SHALL otherwise (RUN, nothing pending) drive all loads 1, bubble_id_ex=0, flush=0.
REQ-024 SHALL set register imem_done when imem_resp=1 and load_if_id=0 in the same cycle; clear it on any cycle with load_if_id=1 or flush=1; imem_hold = imem_done.
REQ-025 SHALL increment stall_cycles on every cycle with load_pc=0, saturating at 16'hFFFF (no wrap).
REQ-026 SHALL produce all outputs other than stall_cycles and imem_hold combinationally from inputs and current state (zero-cycle latency).

Reset
REQ-027 SHALL, on clk edge with reset=1, set state=RUN, imem_done=0, stall_cycles=0, regardless of pending requests.
REQ-028 SHALL, while reset=1, drive all load enables 1, bubble_id_ex=0, flush=0, imem_hold=0.
REQ-029 SHALL, on reset asserted mid-MEM_WAIT, resume in RUN the cycle after reset deasserts with no residual stall.

Verification
REQ-030 SHALL cover load-use: exec LDR R2, ID ADD R3,R2,R1 -> one cycle load_pc=0, load_if_id=0, bubble_id_ex=1; next cycle (exec_mem_read=0) all loads 1; stall_cycles +1.
REQ-031 SHALL cover D-miss: dmem_read=1, dmem_resp=0 for 4 cycles then 1 -> 4 cycles all loads 0, state MEM_WAIT, 5th cycle all loads 1, stall_cycles=4.
REQ-032 SHALL cover fetch-during-freeze: imem_resp=1 in cycle 2 of D-miss -> imem_hold=1 from next cycle until the cycle load_if_id=1, then 0; no ibusy stall after D-miss.
REQ-033 SHALL cover branch vs load-use: mem_br_taken=1 and load_use=1 same cycle -> flush=1, bubble_id_ex=0; next cycle FLUSH_RECOVER with load_use=1 -> no stall.
REQ-034 SHALL cover saturation: force 70000 stall cycles -> stall_cycles holds 16'hFFFF; reset -> 0.
REQ-035 SHALL cover reset mid-MEM_WAIT: reset=1 during dbusy -> loads 1 during reset, state RUN, counter 0 after.
